// File: rtl/aidan_mcnay_range_counter.sv
// Range counter: walks from a latched start to an inclusive latched limit in
// programmable steps, with wrap/stop-at-limit mode and sticky carry detection.
module aidan_mcnay_range_counter #(
    parameter int nbits = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [nbits-1:0] start_val,
    input  logic [nbits-1:0] limit_val,
    input  logic [nbits-1:0] step_val,
    input  logic             latch_val,
    input  logic             en,
    input  logic             wrap_mode,
    output logic [nbits-1:0] out_num,
    output logic             valid,
    output logic             done,
    output logic             wrapped,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [nbits-1:0] count_reg, count_next;
    logic [nbits-1:0] start_reg, start_next;
    logic [nbits-1:0] limit_reg, limit_next;
    logic [nbits-1:0] step_reg, step_next;
    logic             wrap_reg, wrap_next;
    logic             wrapped_reg, wrapped_next;
    logic             overflow_reg, overflow_next;

    logic [nbits:0]   sum;
    logic             carry;
    logic             in_range;

    // One bit wider than the count so a step past all-ones is visible as carry.
    assign sum      = {1'b0, count_reg} + {1'b0, step_reg};
    assign carry    = sum[nbits];
    assign in_range = !carry && (sum[nbits-1:0] <= limit_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count_reg    <= '0;
            start_reg    <= '0;
            limit_reg    <= '0;
            step_reg     <= '0;
            wrap_reg     <= 1'b0;
            wrapped_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state        <= state_next;
            count_reg    <= count_next;
            start_reg    <= start_next;
            limit_reg    <= limit_next;
            step_reg     <= step_next;
            wrap_reg     <= wrap_next;
            wrapped_reg  <= wrapped_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state;
        count_next    = count_reg;
        start_next    = start_reg;
        limit_next    = limit_reg;
        step_next     = step_reg;
        wrap_next     = wrap_reg;
        wrapped_next  = 1'b0;
        overflow_next = overflow_reg;

        if (latch_val) begin
            start_next    = start_val;
            limit_next    = limit_val;
            step_next     = step_val;
            wrap_next     = wrap_mode;
            count_next    = start_val;
            overflow_next = 1'b0;
            state_next    = (start_val <= limit_val) ? COUNT : DONE;
        end else begin
            case (state)
                IDLE: begin
                    count_next = '0;
                end
                COUNT: begin
                    if (en) begin
                        if (in_range) begin
                            count_next = sum[nbits-1:0];
                        end else begin
                            if (carry) begin
                                overflow_next = 1'b1;
                            end
                            // Stop mode keeps the last in-range value on out_num.
                            if (wrap_reg) begin
                                count_next   = start_reg;
                                wrapped_next = 1'b1;
                            end else begin
                                state_next = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    assign out_num  = count_reg;
    assign valid    = (state == COUNT);
    assign done     = (state == DONE);
    assign wrapped  = wrapped_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_aidan_mcnay_range_counter.sv
// Directed bench for aidan_mcnay_range_counter: expected outputs are queued as
// each cycle's stimulus is applied and compared after the following edge.
module tb_aidan_mcnay_range_counter;

    localparam int NB = 16;

    logic          clk;
    logic          reset;
    logic [NB-1:0] start_val;
    logic [NB-1:0] limit_val;
    logic [NB-1:0] step_val;
    logic          latch_val;
    logic          en;
    logic          wrap_mode;
    logic [NB-1:0] out_num;
    logic          valid;
    logic          done;
    logic          wrapped;
    logic          overflow;

    typedef struct {
        string         tag;
        logic [NB-1:0] num;
        logic          valid;
        logic          done;
        logic          wrapped;
        logic          overflow;
    } exp_t;

    exp_t expQueue[$];
    int   checkCount = 0;
    int   passCount  = 0;

    aidan_mcnay_range_counter #(.nbits(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_val (start_val),
        .limit_val (limit_val),
        .step_val  (step_val),
        .latch_val (latch_val),
        .en        (en),
        .wrap_mode (wrap_mode),
        .out_num   (out_num),
        .valid     (valid),
        .done      (done),
        .wrapped   (wrapped),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pops the oldest expectation and compares all outputs as one vector.
    task automatic checkOutput();
        exp_t e;
        logic [NB+3:0] observed;
        logic [NB+3:0] expected;
        if (expQueue.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        e = expQueue.pop_front();
        observed = {out_num, valid, done, wrapped, overflow};
        expected = {e.num, e.valid, e.done, e.wrapped, e.overflow};
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed num=%h v=%b d=%b w=%b o=%b expected num=%h v=%b d=%b w=%b o=%b",
                    e.tag, out_num, valid, done, wrapped, overflow,
                    e.num, e.valid, e.done, e.wrapped, e.overflow);
    endtask

    // Drives one cycle of inputs, queues the result expected after the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic lat, input logic enable,
                                 input logic [NB-1:0] s, input logic [NB-1:0] l, input logic [NB-1:0] st,
                                 input logic wm, input logic [NB-1:0] eNum, input logic eValid,
                                 input logic eDone, input logic eWrapped, input logic eOverflow);
        exp_t e;
        reset     = rst;
        latch_val = lat;
        en        = enable;
        start_val = s;
        limit_val = l;
        step_val  = st;
        wrap_mode = wm;
        e.tag = tag; e.num = eNum; e.valid = eValid; e.done = eDone;
        e.wrapped = eWrapped; e.overflow = eOverflow;
        expQueue.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset = 1'b1; latch_val = 1'b0; en = 1'b0;
        start_val = '0; limit_val = '0; step_val = '0; wrap_mode = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("reset",  1, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            applyStimulus("idle_en", 0, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);

        // Stop mode, exact hit on the limit then done.
        applyStimulus("stop_latch", 0, 1, 0, 3, 11, 2, 0, 16'd3, 1, 0, 0, 0);
        applyStimulus("stop_5",     0, 0, 1, 0, 0, 0, 0, 16'd5, 1, 0, 0, 0);
        applyStimulus("stop_7",     0, 0, 1, 0, 0, 0, 0, 16'd7, 1, 0, 0, 0);
        applyStimulus("stop_9",     0, 0, 1, 0, 0, 0, 0, 16'd9, 1, 0, 0, 0);
        applyStimulus("stop_11",    0, 0, 1, 0, 0, 0, 0, 16'd11, 1, 0, 0, 0);
        applyStimulus("stop_done",  0, 0, 1, 0, 0, 0, 0, 16'd11, 0, 1, 0, 0);
        applyStimulus("done_hold",  0, 0, 1, 0, 0, 0, 0, 16'd11, 0, 1, 0, 0);

        // Wrap mode with a single-cycle wrapped pulse.
        applyStimulus("wrap_latch", 0, 1, 0, 5, 8, 1, 1, 16'd5, 1, 0, 0, 0);
        applyStimulus("wrap_6",     0, 0, 1, 0, 0, 0, 0, 16'd6, 1, 0, 0, 0);
        applyStimulus("wrap_7",     0, 0, 1, 0, 0, 0, 0, 16'd7, 1, 0, 0, 0);
        applyStimulus("wrap_8",     0, 0, 1, 0, 0, 0, 0, 16'd8, 1, 0, 0, 0);
        applyStimulus("wrap_back",  0, 0, 1, 0, 0, 0, 0, 16'd5, 1, 0, 1, 0);
        applyStimulus("wrap_6b",    0, 0, 1, 0, 0, 0, 0, 16'd6, 1, 0, 0, 0);
        applyStimulus("en_low",     0, 0, 0, 0, 0, 0, 0, 16'd6, 1, 0, 0, 0);

        // Carry out of 16 bits in stop mode, then cleared by a re-latch.
        applyStimulus("ovf_latch",  0, 1, 0, 16'hFFF0, 16'hFFFF, 16'h0010, 0, 16'hFFF0, 1, 0, 0, 0);
        applyStimulus("ovf_stop",   0, 0, 1, 0, 0, 0, 0, 16'hFFF0, 0, 1, 0, 1);
        applyStimulus("ovf_sticky", 0, 0, 1, 0, 0, 0, 0, 16'hFFF0, 0, 1, 0, 1);
        applyStimulus("ovf_clear",  0, 1, 0, 16'hFFF0, 16'hFFFF, 16'h0010, 0, 16'hFFF0, 1, 0, 0, 0);

        // Carry out in wrap mode restarts at start with overflow set.
        applyStimulus("wovf_latch", 0, 1, 0, 16'hFFF0, 16'hFFFF, 16'h0008, 1, 16'hFFF0, 1, 0, 0, 0);
        applyStimulus("wovf_fff8",  0, 0, 1, 0, 0, 0, 0, 16'hFFF8, 1, 0, 0, 0);
        applyStimulus("wovf_wrap",  0, 0, 1, 0, 0, 0, 0, 16'hFFF0, 1, 0, 1, 1);

        // Degenerate loads.
        applyStimulus("start_gt_limit", 0, 1, 0, 10, 4, 1, 0, 16'd10, 0, 1, 0, 0);
        applyStimulus("step0_latch",    0, 1, 0, 2, 50, 0, 0, 16'd2, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            applyStimulus("step0_hold", 0, 0, 1, 0, 0, 0, 0, 16'd2, 1, 0, 0, 0);

        // Latch beats en mid-range; reset beats latch.
        applyStimulus("mid_latch", 0, 1, 0, 1, 20, 2, 0, 16'd1, 1, 0, 0, 0);
        applyStimulus("mid_3",     0, 0, 1, 0, 0, 0, 0, 16'd3, 1, 0, 0, 0);
        applyStimulus("mid_5",     0, 0, 1, 0, 0, 0, 0, 16'd5, 1, 0, 0, 0);
        applyStimulus("mid_7",     0, 0, 1, 0, 0, 0, 0, 16'd7, 1, 0, 0, 0);
        applyStimulus("relatch_en", 0, 1, 1, 100, 200, 1, 0, 16'd100, 1, 0, 0, 0);
        applyStimulus("reset_latch", 1, 1, 1, 40, 60, 1, 0, 16'd0, 0, 0, 0, 0);
        applyStimulus("post_reset",  0, 0, 1, 0, 0, 0, 0, 16'd0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
